// File: rtl/icache.sv
// icache: two-way set-associative, read-only instruction cache.
//   256 sets x 2 ways x 4 words (16-byte lines) held in register arrays.
//   Lookup uses the request buffer latched on acceptance; misses are refilled
//   through a single-line burst read. Replacement uses one LRU bit per set.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid/op/index/tag/offset  fetch request (op ignored, offset[1:0] ignored)
//   addr_ok                    request accepted this cycle
//   data_ok/rdata              instruction word returned
//   rd_req/rd_type/rd_addr     line read request to memory, held until rd_rdy
//   rd_rdy                     memory accepted rd_req
//   ret_valid/ret_last/ret_data refill words, last word flagged
//   hit_cnt/miss_cnt           only when ICACHE_PERF_CNT_EN is defined
//
// Optional feature macro: ICACHE_PERF_CNT_EN (hit/miss performance counters).
module icache (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        op,
  input  logic [7:0]  index,
  input  logic [19:0] tag,
  input  logic [3:0]  offset,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] MISS   = 2'd2;
  localparam logic [1:0] REFILL = 2'd3;

  // Every request is a read and fetches are word aligned.
  logic unused_bits;
  assign unused_bits = ^{op, offset[1:0]};

  logic [1:0]  state_q, state_d;
  logic [19:0] req_tag_q, req_tag_d;
  logic [7:0]  req_index_q, req_index_d;
  logic [1:0]  req_word_q, req_word_d;
  logic        victim_q, victim_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0][255:0] vld_q, vld_d;
  logic [255:0] lru_q, lru_d;  // per set: way to replace next

  logic [31:0] data_mem [256][2][4];
  logic [19:0] tag_mem  [256][2];

  logic [1:0] hit_way;
  logic       hit, miss, accept, refill_we, refill_done;

  always_comb begin
    for (int w = 0; w < 2; w++)
      hit_way[w] = vld_q[w][req_index_q] && (tag_mem[req_index_q][w] == req_tag_q);
  end

  assign hit         = (state_q == LOOKUP) && (hit_way != 2'b00);
  assign miss        = (state_q == LOOKUP) && (hit_way == 2'b00);
  assign addr_ok     = (state_q == IDLE) || hit;
  assign accept      = valid && addr_ok;
  assign refill_we   = (state_q == REFILL) && ret_valid;
  assign refill_done = refill_we && ret_last;
  assign data_ok     = hit || refill_done;
  assign rd_req      = (state_q == MISS);
  assign rd_type     = 3'b100;
  assign rd_addr     = rd_req ? {req_tag_q, req_index_q, 4'b0000} : 32'h0;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_index_d = req_index_q;
    req_word_d  = req_word_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    vld_d       = vld_q;
    lru_d       = lru_q;
    rdata       = 32'h0;

    if (accept) begin
      req_tag_d   = tag;
      req_index_d = index;
      req_word_d  = offset[3:2];
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          rdata = data_mem[req_index_q][hit_way[1]][req_word_q];
          lru_d[req_index_q] = ~hit_way[1];
          state_d = accept ? LOOKUP : IDLE;
        end else begin
          if (!vld_q[0][req_index_q])      victim_d = 1'b0;
          else if (!vld_q[1][req_index_q]) victim_d = 1'b1;
          else                             victim_d = lru_q[req_index_q];
          state_d = MISS;
        end
      end
      MISS: begin
        if (rd_rdy) begin
          state_d = REFILL;
          cnt_d   = 2'd0;
        end
      end
      REFILL: begin
        if (ret_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == req_word_q) hold_d = ret_data;
          if (ret_last) begin
            vld_d[victim_q][req_index_q] = 1'b1;
            lru_d[req_index_q] = ~victim_q;
            // The requested word may be the one arriving right now.
            rdata   = (cnt_q == req_word_q) ? ret_data : hold_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_index_q <= '0;
      req_word_q  <= '0;
      victim_q    <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
      vld_q       <= '0;
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_index_q <= req_index_d;
      req_word_q  <= req_word_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      vld_q       <= vld_d;
      lru_q       <= lru_d;
    end
  end

  // NOTE: tag and data arrays are not reset; clearing the valid bits is
  // enough to make their contents unobservable.
  always_ff @(posedge clk) begin
    if (refill_we)   data_mem[req_index_q][victim_q][cnt_q] <= ret_data;
    if (refill_done) tag_mem[req_index_q][victim_q] <= req_tag_q;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, hit};
    miss_cnt_d = miss_cnt_q + {31'd0, miss};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
